// File: rtl/fetch_if.sv
// Fetch-stage bus: imem address/data, ID redirect controls and IF/ID outputs.
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        done;

  modport master (
    input  stall, branch_taken, branch_offset,
    input  jump, jump_target, instruction,
    output pc, if_id_instr, if_id_pc_plus1,
    output if_id_valid, done
  );

  modport slave (
    output stall, branch_taken, branch_offset,
    output jump, jump_target, instruction,
    input  pc, if_id_instr, if_id_pc_plus1,
    input  if_id_valid, done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-indexed PC, IF/ID register,
// ID-resolved branch/jump redirect, stall and end-of-program halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] NUM_INSTR = 32'd3,
  parameter logic [31:0] NOP       = 32'h0
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc1;
    logic        valid;
  } if_id_t;

  state_t      st_q, st_d;
  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic        done_q, done_d;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  assign br_tgt = ifid_q.pc1
    + {{16{bus.branch_offset[15]}}, bus.branch_offset};
  assign jmp_tgt = {ifid_q.pc1[31:26], bus.jump_target};

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    ifid_d = ifid_q;
    done_d = done_q;
    unique case (st_q)
      IDLE: st_d = FETCH;
      FETCH: begin
        // jump and branch may both assert; first match wins
        priority case (1'b1)
          bus.jump: begin
            pc_d         = jmp_tgt;
            ifid_d.instr = NOP;
            ifid_d.valid = 1'b0;
          end
          bus.branch_taken: begin
            pc_d         = br_tgt;
            ifid_d.instr = NOP;
            ifid_d.valid = 1'b0;
          end
          bus.stall: ;
          (pc_q >= NUM_INSTR): begin
            ifid_d.instr = NOP;
            ifid_d.valid = 1'b0;
            done_d       = 1'b1;
            st_d         = HALT;
          end
          default: begin
            ifid_d.instr = bus.instruction;
            ifid_d.pc1   = pc_q + 32'd1;
            ifid_d.valid = 1'b1;
            pc_d         = pc_q + 32'd1;
          end
        endcase
      end
      HALT: begin
        ifid_d.instr = NOP;
        ifid_d.valid = 1'b0;
        done_d       = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= IDLE;
      pc_q   <= RESET_PC;
      ifid_q <= '{instr: NOP, pc1: 32'd0, valid: 1'b0};
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      done_q <= done_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_id_instr    = ifid_q.instr;
  assign bus.if_id_pc_plus1 = ifid_q.pc1;
  assign bus.if_id_valid    = ifid_q.valid;
  assign bus.done           = done_q;

endmodule
